// File: rtl/cpu_pkg.sv
// Shared fetch-side constants: opcodes, HALT encoding, program entry points and FSM states.
package cpu_pkg;

  localparam logic [3:0] OP_BNE    = 4'b1000;
  localparam logic [3:0] OP_BEQ    = 4'b1011;
  localparam logic [8:0] INST_HALT = 9'b1111_11111;

  localparam logic [7:0] START_PROD  = 8'd0;
  localparam logic [7:0] START_STRM  = 8'd30;
  localparam logic [7:0] START_CPAIR = 8'd42;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_branch(input logic [3:0] opcode);
    return (opcode == OP_BNE) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC adder: pc + 1, or pc + sign-extended offset when a branch is taken; wraps modulo 2^PC_W.
module pc_next #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 5
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  input  logic             take_branch,
  output logic [PC_W-1:0]  next_pc
);

  logic signed [PC_W-1:0] step;

  always_comb begin
    if (take_branch) step = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    else             step = PC_W'(1);
    next_pc = pc + $unsigned(step);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// PC / fetch sequencer feeding the instruction ROM; runs one resident program until HALT.
// Optional FETCH_ICOUNT_EN adds a saturating executed-instruction counter on port icount.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int INST_W = 9,
  parameter int OFF_W  = 5,
  parameter int START0 = int'(START_PROD),
  parameter int START1 = int'(START_STRM),
  parameter int START2 = int'(START_CPAIR)
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        prog_sel,
  input  logic [INST_W-1:0] inst,
  input  logic              br_taken,
  input  logic              stall,
  output logic [PC_W-1:0]   pc,
  output logic              inst_valid,
  output logic              busy,
  output logic              done
`ifdef FETCH_ICOUNT_EN
  ,
  output logic [15:0]       icount
`endif
);

  fetch_state_t      state;
  logic [PC_W-1:0]   start_pc;
  logic [PC_W-1:0]   next_pc;
  logic [3:0]        opcode;
  logic [OFF_W-1:0]  offset;
  logic              is_halt;
  logic              take_branch;
  logic              advance;
  logic              launch;

  assign opcode      = inst[INST_W-1 -: 4];
  assign offset      = inst[OFF_W-1:0];
  assign is_halt     = (inst == INST_W'(INST_HALT));
  assign take_branch = is_branch(opcode) & br_taken;
  assign advance     = (state == RUN) & ~stall;
  assign launch      = start & (state != RUN);

  assign inst_valid = advance;
  assign busy       = (state == RUN);
  assign done       = (state == HALTED);

  // prog_sel == 3 falls back to the product program
  always_comb begin
    case (prog_sel)
      2'd1:    start_pc = PC_W'(START1);
      2'd2:    start_pc = PC_W'(START2);
      default: start_pc = PC_W'(START0);
    endcase
  end

  pc_next #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pc_next (
    .pc          (pc),
    .offset      (offset),
    .take_branch (take_branch),
    .next_pc     (next_pc)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      case (state)
        RUN: begin
          // stall freezes everything, including HALT recognition
          if (!stall) begin
            if (is_halt) state <= HALTED;
            else         pc    <= next_pc;
          end
        end
        default: begin
          if (start) begin
            pc    <= start_pc;
            state <= RUN;
          end
        end
      endcase
    end
  end

`ifdef FETCH_ICOUNT_EN
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                         icount <= '0;
    else if (launch)                      icount <= '0;
    else if (advance && icount != 16'hFFFF) icount <= icount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized run against a behavioural model.
module tb_fetch_ctrl;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] prog_sel;
  logic [8:0] inst;
  logic       br_taken;
  logic       stall;
  logic [7:0] pc;
  logic       inst_valid;
  logic       busy;
  logic       done;
`ifdef FETCH_ICOUNT_EN
  logic [15:0] icount;
`endif

  fetch_ctrl dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .start      (start),
    .prog_sel   (prog_sel),
    .inst       (inst),
    .br_taken   (br_taken),
    .stall      (stall),
    .pc         (pc),
    .inst_valid (inst_valid),
    .busy       (busy),
    .done       (done)
`ifdef FETCH_ICOUNT_EN
    ,
    .icount     (icount)
`endif
  );

  always #5 CLK = ~CLK;

  int   total = 0;
  int   bad   = 0;

  // reference model: running/done flags, pc as an integer, executed-instruction count
  bit   m_run, m_done;
  int   m_pc, m_ic;
  logic iv_seen, exp_iv;

  localparam logic [8:0] NOP  = 9'b0000_00000;
  localparam logic [8:0] HALT = 9'b1111_11111;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pc = 0; m_ic = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // drive one cycle of inputs, advance the model, return just after the edge
  task automatic step(input bit st, input int sel, input logic [8:0] ins, input bit br, input bit stl);
    int off;
    start = st; prog_sel = sel[1:0]; inst = ins; br_taken = br; stall = stl;
    #1;
    iv_seen = inst_valid;
    exp_iv  = m_run && !stl;
    if (m_run) begin
      if (!stl) begin
        if (m_ic < 65535) m_ic++;
        if (ins == HALT) begin
          m_run = 0; m_done = 1;
        end else if ((ins[8:5] == 4'b1000 || ins[8:5] == 4'b1011) && br) begin
          off = int'(ins[4:0]);
          if (off > 15) off -= 32;
          m_pc = (m_pc + off + 256) % 256;
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end
    end else if (st) begin
      m_pc = (sel == 1) ? 30 : (sel == 2) ? 42 : 0;
      m_run = 1; m_done = 0; m_ic = 0;
    end
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; prog_sel = 0; inst = NOP; br_taken = 0; stall = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    total++; if (pc !== 8'd0)      begin bad++; $display("FAIL reset_pc got=%0d want=0", pc); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_iv got=%b want=0", inst_valid); end
    reset_n = 1'b1;
    step(0, 0, NOP, 0, 0);
    total++; if ({pc, busy} !== 9'd0) begin bad++; $display("FAIL idle_hold pc=%0d busy=%b want 0/0", pc, busy); end
  endtask

  task automatic test_start_seq();
    step(1, 1, NOP, 0, 0);
    total++; if (pc !== 8'd30 || busy !== 1'b1) begin bad++; $display("FAIL start_sel1 pc=%0d busy=%b want 30/1", pc, busy); end
    step(0, 0, NOP, 0, 0);
    total++; if (pc !== 8'd31) begin bad++; $display("FAIL seq_31 got=%0d want=31", pc); end
    total++; if (iv_seen !== 1'b1) begin bad++; $display("FAIL seq_iv got=%b want=1", iv_seen); end
    step(0, 0, NOP, 0, 0);
    total++; if (pc !== 8'd32) begin bad++; $display("FAIL seq_32 got=%0d want=32", pc); end
    step(1, 2, NOP, 0, 0);
    total++; if (pc !== 8'd33 || busy !== 1'b1) begin bad++; $display("FAIL start_in_run pc=%0d busy=%b want 33/1", pc, busy); end
  endtask

  task automatic test_branch();
    do_reset();
    step(1, 3, NOP, 0, 0);
    total++; if (pc !== 8'd0) begin bad++; $display("FAIL sel3_alias got=%0d want=0", pc); end
    step(0, 0, 9'b1000_01010, 1, 0);
    total++; if (pc !== 8'd10) begin bad++; $display("FAIL bne_fwd got=%0d want=10", pc); end
    step(0, 0, 9'b1000_11000, 0, 0);
    total++; if (pc !== 8'd11) begin bad++; $display("FAIL bne_not_taken got=%0d want=11", pc); end
    step(0, 0, 9'b1011_11111, 1, 0);
    total++; if (pc !== 8'd10) begin bad++; $display("FAIL beq_back1 got=%0d want=10", pc); end
    step(0, 0, 9'b1000_11000, 1, 0);
    total++; if (pc !== 8'd2) begin bad++; $display("FAIL bne_back8 got=%0d want=2", pc); end
    step(0, 0, 9'b1000_11000, 1, 0);
    total++; if (pc !== 8'd250) begin bad++; $display("FAIL wrap_down got=%0d want=250", pc); end
    step(0, 0, 9'b0000_00101, 1, 0);
    total++; if (pc !== 8'd251) begin bad++; $display("FAIL nonbranch_br got=%0d want=251", pc); end
    repeat (4) step(0, 0, NOP, 0, 0);
    total++; if (pc !== 8'd255) begin bad++; $display("FAIL reach_255 got=%0d want=255", pc); end
    step(0, 0, NOP, 0, 0);
    total++; if (pc !== 8'd0) begin bad++; $display("FAIL wrap_up got=%0d want=0", pc); end
    repeat (2) step(0, 0, 9'b1011_00000, 1, 0);
    total++; if (pc !== 8'd0 || busy !== 1'b1) begin bad++; $display("FAIL spin pc=%0d busy=%b want 0/1", pc, busy); end
  endtask

  task automatic test_stall();
    step(0, 0, 9'b1011_00101, 1, 0);
    total++; if (pc !== 8'd5) begin bad++; $display("FAIL to_5 got=%0d want=5", pc); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 9'b1011_00111, 1, 1);
      total++; if (pc !== 8'd5 || iv_seen !== 1'b0) begin bad++; $display("FAIL stall_%0d pc=%0d iv=%b want 5/0", i, pc, iv_seen); end
    end
    step(0, 0, 9'b1011_00111, 1, 0);
    total++; if (pc !== 8'd12) begin bad++; $display("FAIL stall_release got=%0d want=12", pc); end
  endtask

  task automatic test_halt();
    step(0, 0, 9'b1000_01111, 1, 0);
    step(0, 0, NOP, 0, 0);
    step(0, 0, NOP, 0, 0);
    total++; if (pc !== 8'd29) begin bad++; $display("FAIL to_29 got=%0d want=29", pc); end
    step(0, 0, HALT, 0, 1);
    total++; if ({busy, done} !== 2'b10 || pc !== 8'd29) begin bad++; $display("FAIL halt_stalled busy/done=%b pc=%0d want 10/29", {busy, done}, pc); end
    step(0, 0, HALT, 0, 0);
    total++; if ({busy, done} !== 2'b01 || pc !== 8'd29) begin bad++; $display("FAIL halt busy/done=%b pc=%0d want 01/29", {busy, done}, pc); end
    step(0, 0, NOP, 1, 0);
    total++; if ({busy, done} !== 2'b01 || pc !== 8'd29 || iv_seen !== 1'b0) begin bad++; $display("FAIL halted_hold busy/done=%b pc=%0d iv=%b", {busy, done}, pc, iv_seen); end
    step(1, 2, NOP, 0, 0);
    total++; if (pc !== 8'd42 || {busy, done} !== 2'b10) begin bad++; $display("FAIL restart pc=%0d busy/done=%b want 42/10", pc, {busy, done}); end
  endtask

  task automatic test_async_reset();
    repeat (5) step(0, 0, NOP, 0, 0);
    total++; if (pc !== 8'd47) begin bad++; $display("FAIL to_47 got=%0d want=47", pc); end
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (pc !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL async_reset pc=%0d busy=%b want 0/0", pc, busy); end
    #1;
    reset_n = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_random();
    bit st, br, stl;
    int sel;
    logic [8:0] ins;
    step(1, $urandom_range(0, 3), NOP, 0, 0);
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 3);
      ins = ($urandom_range(0, 24) == 0) ? HALT : 9'($urandom);
      if ($urandom_range(0, 2) == 0) ins[8:5] = ($urandom_range(0, 1) == 0) ? 4'b1000 : 4'b1011;
      br  = $urandom_range(0, 1) == 1;
      stl = ($urandom_range(0, 3) == 0);
      step(st, sel, ins, br, stl);
      total++;
      if (iv_seen !== exp_iv || {pc, busy, done} !== {m_pc[7:0], m_run, m_done}) begin
        bad++;
        $display("FAIL rand_%0d pc=%0d busy=%b done=%b iv=%b want pc=%0d busy=%b done=%b iv=%b",
                 i, pc, busy, done, iv_seen, m_pc, m_run, m_done, exp_iv);
      end
`ifdef FETCH_ICOUNT_EN
      total++;
      if (icount !== m_ic[15:0]) begin bad++; $display("FAIL rand_icount_%0d got=%0d want=%0d", i, icount, m_ic); end
`endif
    end
  endtask

`ifdef FETCH_ICOUNT_EN
  task automatic test_icount();
    do_reset();
    step(1, 0, NOP, 0, 0);
    total++; if (icount !== 16'd0) begin bad++; $display("FAIL icount_start got=%0d want=0", icount); end
    for (int i = 0; i < 19; i++) begin
      if (i == 7) step(0, 0, NOP, 0, 1);
      step(0, 0, NOP, 0, 0);
    end
    step(0, 0, HALT, 0, 0);
    total++; if (icount !== 16'd20 || done !== 1'b1) begin bad++; $display("FAIL icount_run got=%0d done=%b want 20/1", icount, done); end
    step(1, 1, NOP, 0, 0);
    total++; if (icount !== 16'd0) begin bad++; $display("FAIL icount_clear got=%0d want=0", icount); end
  endtask
`endif

  initial begin
    test_reset();
    test_start_seq();
    test_branch();
    test_stall();
    test_halt();
    test_async_reset();
    test_random();
`ifdef FETCH_ICOUNT_EN
    test_icount();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter and fetch sequencer that sits directly upstream of the instruction ROM.
- Drives the ROM address (`pc`) and receives the 9-bit instruction back combinationally.
- Selects one of three resident programs (product, string match, closest pair) by start address.
- Steps the PC sequentially or by signed branch offset, detects HALT, and reports done to the testbench/top level.

Parameters:
- PC_W, 8, program counter / ROM address width
- INST_W, 9, instruction width
- OFF_W, 5, branch offset field width (inst[4:0])
- START0, 0, entry PC for prog_sel=0 (product)
- START1, 30, entry PC for prog_sel=1 (string match)
- START2, 42, entry PC for prog_sel=2 (closest pair)

Ports:
- CLK  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; launches program selected by prog_sel
- prog_sel  in  2  program select; value 3 aliases to START0
- inst  in  INST_W  instruction returned combinationally by ROM for current pc
- br_taken  in  1  from execute: condition for branch at current pc is true
- stall  in  1  hold pc this cycle (multi-cycle op downstream)
- pc  out  PC_W  registered ROM address
- inst_valid  out  1  pc/inst pair is live and will be executed this cycle
- busy  out  1  program running
- done  out  1  HALT reached; sticky until next start

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=0, busy=0, done=0, inst_valid=0.
- FSM states: IDLE, RUN, HALTED.
- IDLE: on start -> pc=START[prog_sel], go to RUN next edge. busy=1 from that edge.
- RUN:
  - inst_valid = ~stall.
  - If stall=1: pc holds, br_taken ignored.
  - Else if inst == 9'b1111_11111 (HALT): pc holds, go to HALTED; busy=0, done=1 on that edge.
  - Else if opcode inst[8:5] is BNE (4'b1000) or BEQ (4'b1011) and br_taken=1: pc <= pc + sign_extend(inst[4:0]).
  - Else: pc <= pc + 1.
  - br_taken is ignored for non-branch opcodes.
- HALTED: pc holds; done=1, busy=0. On start -> pc=START[prog_sel], done=0, go to RUN.
- start during RUN is ignored; no restart mid-program.
- Latency: pc update visible one edge after the decision; ROM path is combinational, so one instruction per unstalled cycle.
- Arithmetic: all pc arithmetic is modulo 2^PC_W. 255+1 wraps to 0; 2 + (-8) wraps to 250. No error flag.
- Offset 0 with branch taken: pc holds, so the instruction re-executes each cycle (legal spin loop).
- HALT under stall: stall wins; HALT is recognised on the first unstalled cycle.
- reset_n asserted mid-RUN: immediate return to IDLE and pc=0 regardless of CLK.

Optional Feature:
- Macro FETCH_ICOUNT_EN.
- Defined: adds output icount [15:0].
  - Cleared on reset and on each accepted start.
  - Increments on every cycle with inst_valid=1, including the HALT instruction.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; no other behaviour changes.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_BNE=4'b1000, OP_BEQ=4'b1011, INST_HALT=9'b1111_11111;
  - start-address constants;
  - enum fetch_state_t {IDLE, RUN, HALTED}.
- One natural sub-module: pc_next (combinational next-PC adder: pc, offset, take_branch -> next_pc). The FSM stays in fetch_ctrl.

Test Plan:
- Reset then start, prog_sel=1, inst=9'b0000_00000, br_taken=0 -> pc=30,31,32 on successive edges; busy=1; inst_valid=1.
- pc=10, inst=9'b1000_11000, br_taken=1 -> next pc=2 (10-8); with br_taken=0 -> next pc=11.
- stall=1 for 3 cycles at pc=5 with a taken BEQ present -> pc stays 5 and inst_valid=0; after release with br_taken=1 and offset 00111 -> pc=12.
- inst=9'b1111_11111 at pc=29 -> HALTED next edge; done=1, busy=0, pc=29. Later start with prog_sel=2 -> pc=42, done=0.
- Wrap: pc=255, non-branch inst -> pc=0. pc=2 with taken branch offset 11000 -> pc=250.
- reset_n low mid-RUN at pc=47 between edges -> pc=0 and IDLE immediately. With FETCH_ICOUNT_EN, a 20-instruction run ending in HALT -> icount=20.
